// File: rtl/inst_rom_loader_if.sv
// Fetch-port and host-loader signal bundle for inst_rom_loader.
// master = core/host side, slave = the ROM loader itself.
interface inst_rom_loader_if #(
   parameter int ROM_AW = 10
);
   logic              rom_ce_i;
   logic [31:0]       rom_addr_i;
   logic [31:0]       rom_data_o;
   logic              ld_start_i;
   logic              ld_valid_i;
   logic [7:0]        ld_byte_i;
   logic              ld_last_i;
   logic              ld_ready_o;
   logic              ld_busy_o;
   logic              ld_done_o;
   logic [ROM_AW:0]   ld_count_o;
   logic              ld_err_o;

   modport master (
      output rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
      input  rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, ld_count_o, ld_err_o
   );

   modport slave (
      input  rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
      output rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, ld_count_o, ld_err_o
   );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory with a zero-latency fetch port and a byte-serial,
// big-endian program loader that fills it from a host stream.
module inst_rom_loader #(
   parameter int ROM_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   inst_rom_loader_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [ROM_AW:0] CNT_ONE = {{ROM_AW{1'b0}}, 1'b1};

   logic [31:0]     mem [2**ROM_AW];

   logic [1:0]      state_q, state_d;
   logic [ROM_AW:0] count_q, count_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [31:0]     buf_q, buf_d;
   logic            err_q, err_d;

   logic            accept;
   logic            full;
   logic            wr_en;
   logic [31:0]     byte_word;
   logic [31:0]     wr_data;
   logic            busy;
   logic            addr_in_range;

   // The word counter doubles as the write pointer; its MSB set means the memory is full.
   assign full   = count_q[ROM_AW];
   assign accept = (state_q == S_LOAD) && bus.ld_valid_i;
   assign busy   = (state_q != S_IDLE);

   always_comb begin
      byte_word = 32'h0;
      case (byte_idx_q)
         2'd0:    byte_word = {bus.ld_byte_i, 24'h0};
         2'd1:    byte_word = {8'h0, bus.ld_byte_i, 16'h0};
         2'd2:    byte_word = {16'h0, bus.ld_byte_i, 8'h0};
         default: byte_word = {24'h0, bus.ld_byte_i};
      endcase
   end

   // Unfilled lanes stay zero because the buffer restarts from zero for every word.
   assign wr_data = buf_q | byte_word;
   assign wr_en   = accept && !full && ((byte_idx_q == 2'd3) || bus.ld_last_i);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      buf_d      = buf_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ld_start_i) begin
               state_d    = S_LOAD;
               count_d    = '0;
               byte_idx_d = 2'd0;
               buf_d      = 32'h0;
               err_d      = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (full) begin
                  err_d = 1'b1;
               end else if (wr_en) begin
                  count_d    = count_q + CNT_ONE;
                  byte_idx_d = 2'd0;
                  buf_d      = 32'h0;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  buf_d      = wr_data;
               end
               if (bus.ld_last_i) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         byte_idx_q <= 2'd0;
         buf_q      <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         buf_q      <= buf_d;
         err_q      <= err_d;
      end
   end

   // Memory contents deliberately survive reset so a reset mid-load keeps finished words.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[count_q[ROM_AW-1:0]] <= wr_data;
      end
   end

   assign addr_in_range = ((bus.rom_addr_i >> (ROM_AW + 2)) == 32'h0);

   always_comb begin
      bus.rom_data_o = 32'h0;
      if (bus.rom_ce_i && addr_in_range && !busy) begin
         bus.rom_data_o = mem[bus.rom_addr_i[ROM_AW+1:2]];
      end
   end

   assign bus.ld_ready_o = (state_q == S_LOAD);
   assign bus.ld_busy_o  = busy;
   assign bus.ld_done_o  = (state_q == S_DONE);
   assign bus.ld_count_o = count_q;
   assign bus.ld_err_o   = err_q;

endmodule
